// File: rtl/rfsoc_axil2reg.sv
// -----------------------------------------------------------------------------
// rfsoc_axil2reg
//   AXI4-Lite slave to simple register-file bridge. Accepts one AXI4-Lite
//   transaction at a time and turns it into a single-cycle write strobe or a
//   combinational register read.
//
// Ports
//   clk, rstb                       clock (rising edge), async active-low reset
//   s_aw*/s_w*/s_b*                 AXI4-Lite write address/data/response
//   s_ar*/s_r*                      AXI4-Lite read address/response
//   reg_wren                        one-cycle write strobe to the register file
//   reg_offset                      word-aligned byte offset (bits [1:0] = 0)
//   reg_wdata, reg_wstrb            write data and byte enables
//   reg_rdata                       combinational read data for reg_offset
//   dbg_state                       current FSM state (debug visibility)
//
// Handshake semantics: a transfer on any channel happens on the rising edge
// where both valid and ready are high. A valid, once raised by the bridge
// (s_bvalid, s_rvalid), stays high with its payload stable until the matching
// ready is seen; readies are combinational and may be high without valid.
// -----------------------------------------------------------------------------
module rfsoc_axil2reg #(
  parameter logic [15:0] REG_SPACE = 16'h0200
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [15:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [15:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic        reg_wren,
  output logic [15:0] reg_offset,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_wstrb,
  input  logic [31:0] reg_rdata,
  output logic [2:0]  dbg_state
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_CAPTURE = 3'd1,
    S_WR_STROBE  = 3'd2,
    S_WR_RESP    = 3'd3,
    S_RD_SETTLE  = 3'd4,
    S_RD_RESP    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_prio_rd;     // 1: read wins the next contended arbitration
  logic        r_aw_cap;
  logic        r_w_cap;
  logic [13:0] r_awaddr;      // word address only; byte lanes come from wstrb
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wr_err;
  logic        r_rd_err;

  logic        w_grant_rd;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_aw_have;
  logic        w_w_have;
  logic        w_enter_strobe;
  logic [13:0] w_awaddr_now;
  logic [31:0] w_wdata_now;
  logic [3:0]  w_wstrb_now;
  logic        w_aw_oor;
  logic        w_ar_oor;
  logic        w_unused_addr_lsbs;

  function automatic logic out_of_range(input logic [13:0] word_addr);
    return {word_addr, 2'b00} >= REG_SPACE;
  endfunction

  // The half captured on the edge that enters WR_STROBE has not reached its
  // latch yet, so take it straight from the bus in that case.
  assign w_awaddr_now = r_aw_cap ? r_awaddr : s_awaddr[15:2];
  assign w_wdata_now  = r_w_cap  ? r_wdata  : s_wdata;
  assign w_wstrb_now  = r_w_cap  ? r_wstrb  : s_wstrb;
  assign w_aw_oor     = out_of_range(w_awaddr_now);
  assign w_ar_oor     = out_of_range(s_araddr[15:2]);

  assign w_unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};
  assign dbg_state = r_state;

  // Next state and channel readies
  always_comb begin
    w_state_nxt = r_state;
    s_awready   = 1'b0;
    s_wready    = 1'b0;
    s_arready   = 1'b0;
    // A lone read goes straight through; against a pending write the read
    // only wins when the previous transaction was a write.
    w_grant_rd  = s_arvalid && (!(s_awvalid || s_wvalid) || r_prio_rd);

    case (r_state)
      S_IDLE: begin
        s_arready = w_grant_rd;
        s_awready = !w_grant_rd;
        s_wready  = !w_grant_rd;
      end
      S_WR_CAPTURE: begin
        s_awready = !r_aw_cap;
        s_wready  = !r_w_cap;
      end
      default: ;
    endcase

    w_aw_hs   = s_awvalid && s_awready;
    w_w_hs    = s_wvalid  && s_wready;
    w_ar_hs   = s_arvalid && s_arready;
    w_aw_have = r_aw_cap || w_aw_hs;
    w_w_have  = r_w_cap  || w_w_hs;

    case (r_state)
      S_IDLE: begin
        if (w_ar_hs)                     w_state_nxt = S_RD_SETTLE;
        else if (w_aw_have && w_w_have)  w_state_nxt = S_WR_STROBE;
        else if (w_aw_have || w_w_have)  w_state_nxt = S_WR_CAPTURE;
      end
      S_WR_CAPTURE: if (w_aw_have && w_w_have) w_state_nxt = S_WR_STROBE;
      S_WR_STROBE:  w_state_nxt = S_WR_RESP;
      S_WR_RESP:    if (s_bready) w_state_nxt = S_IDLE;
      S_RD_SETTLE:  w_state_nxt = S_RD_RESP;
      S_RD_RESP:    if (s_rready) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase

    w_enter_strobe = (w_state_nxt == S_WR_STROBE) && (r_state != S_WR_STROBE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath: latches, register-file side and response registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_prio_rd  <= 1'b0;
      r_aw_cap   <= 1'b0;
      r_w_cap    <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_err   <= 1'b0;
      r_rd_err   <= 1'b0;
      reg_wren   <= 1'b0;
      reg_offset <= '0;
      reg_wdata  <= '0;
      reg_wstrb  <= '0;
      s_bvalid   <= 1'b0;
      s_bresp    <= RESP_OKAY;
      s_rvalid   <= 1'b0;
      s_rresp    <= RESP_OKAY;
      s_rdata    <= '0;
    end else begin
      reg_wren <= 1'b0;

      if (w_aw_hs) r_awaddr <= s_awaddr[15:2];
      if (w_w_hs) begin
        r_wdata <= s_wdata;
        r_wstrb <= s_wstrb;
      end

      if (w_enter_strobe) begin
        r_aw_cap   <= 1'b0;
        r_w_cap    <= 1'b0;
        reg_offset <= {w_awaddr_now, 2'b00};
        reg_wdata  <= w_wdata_now;
        reg_wstrb  <= w_wstrb_now;
        reg_wren   <= !w_aw_oor;
        r_wr_err   <= w_aw_oor;
      end else begin
        if (w_aw_hs) r_aw_cap <= 1'b1;
        if (w_w_hs)  r_w_cap  <= 1'b1;
      end

      // The offset is presented one cycle early so reg_rdata has a full
      // cycle to settle before it is sampled in RD_SETTLE.
      if (w_ar_hs) begin
        reg_offset <= {s_araddr[15:2], 2'b00};
        r_rd_err   <= w_ar_oor;
      end

      case (r_state)
        S_WR_STROBE: begin
          s_bvalid <= 1'b1;
          s_bresp  <= r_wr_err ? RESP_SLVERR : RESP_OKAY;
        end
        S_WR_RESP: if (s_bready) begin
          s_bvalid  <= 1'b0;
          r_prio_rd <= 1'b1;
        end
        S_RD_SETTLE: begin
          s_rvalid <= 1'b1;
          s_rdata  <= r_rd_err ? 32'h0 : reg_rdata;
          s_rresp  <= r_rd_err ? RESP_SLVERR : RESP_OKAY;
        end
        S_RD_RESP: if (s_rready) begin
          s_rvalid  <= 1'b0;
          r_prio_rd <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rfsoc_axil2reg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rfsoc_axil2reg
//   Directed and randomized bench for the AXI4-Lite to register bridge. A
//   register-file model answers reg_rdata and absorbs reg_wren; a separate
//   word-array reference model predicts every response from the bus traffic.
// -----------------------------------------------------------------------------
module tb_rfsoc_axil2reg;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstb;
  always #5 clk = ~clk;

  logic [15:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [15:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic        reg_wren;
  logic [15:0] reg_offset;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata;
  logic [2:0]  dbg_state;

  rfsoc_axil2reg #(.REG_SPACE(16'h0200)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .s_awaddr   (s_awaddr),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_bresp    (s_bresp),
    .s_bvalid   (s_bvalid),
    .s_bready   (s_bready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .reg_wren   (reg_wren),
    .reg_offset (reg_offset),
    .reg_wdata  (reg_wdata),
    .reg_wstrb  (reg_wstrb),
    .reg_rdata  (reg_rdata),
    .dbg_state  (dbg_state)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int wren_cnt = 0;

  // ---------------- register-file model (environment) ----------------
  logic [31:0] mem_rf [0:255];
  bit          rf_init = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  assign reg_rdata = mem_rf[reg_offset[9:2]];

  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 256; i++) mem_rf[i] = init_word(i);
      rf_init = 1'b1;
    end
    if (reg_wren) begin
      wren_cnt++;
      for (int b = 0; b < 4; b++)
        if (reg_wstrb[b]) mem_rf[reg_offset[9:2]][8*b +: 8] = reg_wdata[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  // 512-byte register space = 128 words; anything beyond is an error.
  logic [31:0] exp_mem [0:127];

  function automatic bit in_range(input logic [15:0] a);
    return (int'(a) / 4) * 4 < 512;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st);
    if (in_range(a))
      for (int b = 0; b < 4; b++)
        if (st[b]) exp_mem[int'(a) / 4][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    return in_range(a) ? exp_mem[int'(a) / 4] : 32'h0;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_bvalid"},  s_bvalid,   0);
    chk({pfx, "_rvalid"},  s_rvalid,   0);
    chk({pfx, "_bresp"},   s_bresp,    0);
    chk({pfx, "_rresp"},   s_rresp,    0);
    chk({pfx, "_rdata"},   s_rdata,    0);
    chk({pfx, "_wren"},    reg_wren,   0);
    chk({pfx, "_offset"},  reg_offset, 0);
    chk({pfx, "_wdata"},   reg_wdata,  0);
    chk({pfx, "_wstrb"},   reg_wstrb,  0);
  endtask

  // ---------------- driver tasks ----------------
  // Issues AW and W (each after its own delay in cycles), checks the strobe
  // cycle and returns at the falling edge where bvalid is first visible.
  task automatic wr_issue(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int aw_dly, input int w_dly, output logic [1:0] exp_resp);
    int cyc;
    bit aw_done;
    bit w_done;
    int wren0;
    bit ok;
    cyc = 0; aw_done = 0; w_done = 0;
    ok = in_range(a);
    exp_resp = ok ? 2'b00 : 2'b10;
    @(posedge clk); #1;
    wren0 = wren_cnt;
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    while (!(aw_done && w_done)) begin
      s_awvalid = !aw_done && (cyc >= aw_dly);
      s_wvalid  = !w_done  && (cyc >= w_dly);
      @(negedge clk);
      if (w_done)  chk("wr_wready_after_capture",  s_wready,  0);
      if (aw_done) chk("wr_awready_after_capture", s_awready, 0);
      if (s_awvalid && s_awready) aw_done = 1;
      if (s_wvalid && s_wready)   w_done  = 1;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 60) begin
        chk("wr_handshake_timeout", 1, 0);
        break;
      end
    end
    s_awvalid = 0; s_wvalid = 0;
    chk("wr_no_early_wren", wren_cnt, wren0);
    @(negedge clk);
    chk("wr_strobe_wren",   reg_wren,   ok);
    chk("wr_strobe_offset", reg_offset, a & 16'hFFFC);
    chk("wr_strobe_wdata",  reg_wdata,  d);
    chk("wr_strobe_wstrb",  reg_wstrb,  st);
    chk("wr_bvalid_early",  s_bvalid,   0);
    model_write(a, d, st);
    @(negedge clk);
    chk("wr_bvalid_n2",     s_bvalid,   1);
    chk("wr_bresp",         s_bresp,    exp_resp);
    chk("wr_wren_one_cyc",  reg_wren,   0);
    chk("wr_wren_count",    wren_cnt,   wren0 + (ok ? 1 : 0));
  endtask

  task automatic wr_finish(input int b_dly, input logic [1:0] exp_resp);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("wr_bvalid_hold", s_bvalid, 1);
      chk("wr_bresp_hold",  s_bresp,  exp_resp);
    end
    @(posedge clk); #1;
    s_bready = 1;
    @(negedge clk);
    chk("wr_bvalid_at_hs", s_bvalid, 1);
    @(posedge clk); #1;
    s_bready = 0;
    @(negedge clk);
    chk("wr_bvalid_cleared", s_bvalid, 0);
  endtask

  task automatic rd_txn(input logic [15:0] a, input int r_dly);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int  wren0;
    bit  got;
    exp_d = model_read(a);
    exp_r = in_range(a) ? 2'b00 : 2'b10;
    got = 0;
    @(posedge clk); #1;
    wren0 = wren_cnt;
    s_araddr = a; s_arvalid = 1;
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      if (s_arready) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) chk("rd_arready_timeout", 1, 0);
    @(posedge clk); #1;
    s_arvalid = 0;
    @(negedge clk);
    chk("rd_rvalid_early", s_rvalid, 0);
    chk("rd_no_wren",      reg_wren, 0);
    @(negedge clk);
    chk("rd_rvalid_n2", s_rvalid, 1);
    chk("rd_rdata",     s_rdata,  exp_d);
    chk("rd_rresp",     s_rresp,  exp_r);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("rd_rvalid_hold", s_rvalid, 1);
      chk("rd_rdata_hold",  s_rdata,  exp_d);
      chk("rd_rresp_hold",  s_rresp,  exp_r);
    end
    @(posedge clk); #1;
    s_rready = 1;
    @(negedge clk);
    chk("rd_rvalid_at_hs", s_rvalid, 1);
    @(posedge clk); #1;
    s_rready = 0;
    @(negedge clk);
    chk("rd_rvalid_cleared", s_rvalid, 0);
    chk("rd_wren_count",     wren_cnt, wren0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  resp;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  st;
    logic [31:0] d39;
    int          k;
    int          seq[$];

    for (int i = 0; i < 128; i++) exp_mem[i] = init_word(i);

    rstb = 0;
    s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0;
    s_bready = 0; s_araddr = 0; s_arvalid = 0; s_rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_awready", s_awready, 1);
    chk("reset_wready",  s_wready,  1);
    chk("reset_arready", s_arready, 0);
    @(posedge clk); #1;
    rstb = 1;

    // AW and W together
    wr_issue(16'h0004, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
    chk("same_cycle_bresp_okay", resp, 2'b00);
    wr_finish(0, resp);

    // W three cycles ahead of AW, unaligned address
    wr_issue(16'h0019, 32'hCAFE_F00D, 4'h2, 3, 0, resp);
    wr_finish(1, resp);
    rd_txn(16'h0018, 0);

    // read with slow rready
    wr_issue(16'h0010, 32'h1234_5678, 4'hF, 1, 0, resp);
    wr_finish(0, resp);
    rd_txn(16'h0010, 5);

    // out-of-range accesses
    wr_issue(16'h0300, 32'h5555_AAAA, 4'hF, 0, 1, resp);
    wr_finish(2, resp);
    rd_txn(16'h0204, 1);
    rd_txn(16'h01FC, 0);

    // reset while a write half is captured: nothing may come out of it
    @(posedge clk); #1;
    s_awaddr = 16'h0008; s_wdata = 32'h0BAD_0BAD; s_wstrb = 4'hF; s_wvalid = 1;
    @(posedge clk); #1;
    s_wvalid = 0;
    k = wren_cnt;
    #2 rstb = 0;
    #1 chk_reset_outputs("rst_capture");
    @(posedge clk); #1;
    rstb = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_capture_no_wren",   wren_cnt, k);
    chk("rst_capture_no_bvalid", s_bvalid, 0);
    wr_issue(16'h0008, 32'h600D_F00D, 4'hF, 0, 2, resp);
    wr_finish(0, resp);

    // reset while waiting in the write response
    wr_issue(16'h0020, 32'h7777_1111, 4'hF, 0, 0, resp);
    #2 rstb = 0;
    #1 chk_reset_outputs("rst_bresp");
    @(posedge clk); #1;
    rstb = 1;
    wr_issue(16'h000C, 32'h0102_0304, 4'h5, 0, 0, resp);
    wr_finish(0, resp);
    rd_txn(16'h000C, 0);
    rd_txn(16'h0020, 0);

    // AW, W and AR all held valid straight out of reset
    @(posedge clk); #1;
    d39 = $urandom;
    rstb = 0;
    s_awaddr = 16'h0030; s_araddr = 16'h0030; s_wdata = d39; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 1; s_rready = 1;
    @(posedge clk); #1;
    rstb = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_bvalid && s_bready) seq.push_back(0);
      if (s_rvalid && s_rready) begin
        seq.push_back(1);
        chk("alt_rdata", s_rdata, d39);
      end
    end
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    repeat (5) @(posedge clk);
    #1;
    s_bready = 0; s_rready = 0;
    chk("alt_progress", (seq.size() >= 8) ? 1 : 0, 1);
    foreach (seq[i]) chk("alt_order", seq[i], i % 2);
    exp_mem[12] = d39;

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'h0200, 16'hFFFF))
                                     : 16'($urandom_range(0, 16'h003F));
      if ($urandom_range(0, 1) == 1) begin
        d  = $urandom;
        st = 4'($urandom_range(0, 15));
        wr_issue(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), resp);
        wr_finish($urandom_range(0, 3), resp);
      end else begin
        rd_txn(a, $urandom_range(0, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
